clock_phase_seq: RTL and testbench
==================================

Name: clock_phase_seq

Overview:
- Sits directly downstream of the processor's clock divider.
- Samples the divided-clock level (clk_div) in the fast clk domain and turns each divided-clock edge into single-cycle phase-enable strobes: fetch/decode/execute/writeback style, one-hot, NUM_PHASES per instruction cycle.
- Adds run/halt control, a single-step handshake and an instruction-cycle counter, so all processor stages clock on clk with enables instead of on a derived clock.

Parameters:
- NUM_PHASES, 4, phases per instruction cycle. Legal range 2..8.
- PHASE_W, 3, width of the phase index. Must satisfy 2^PHASE_W >= NUM_PHASES.
- MAX_GAP, 8, watchdog limit in clk cycles without a clk_div edge. Used only with the optional feature.

Ports:
- clk  in  1  fast system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- clk_div  in  1  divided-clock level from the divider, synchronous to clk.
- run  in  1  level; 1 = free-run instruction cycles.
- step_req  in  1  single-step request; rising edge sampled.
- step_ack  out  1  one-cycle pulse when a stepped instruction cycle completes.
- rise_pulse  out  1  one-cycle pulse per clk_div rising edge.
- fall_pulse  out  1  one-cycle pulse per clk_div falling edge.
- phase  out  PHASE_W  index of the next phase to issue.
- phase_en  out  NUM_PHASES  one-hot, one-cycle phase strobe; 0 otherwise.
- cycle_cnt  out  32  completed instruction cycles.
- busy  out  1  1 in RUN, STEP or DRAIN.
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately without a clk edge. During reset:
  - d_q=0, state=IDLE, phase=0.
  - phase_en=0, rise_pulse=0, fall_pulse=0, step_ack=0.
  - cycle_cnt=0, busy=0, stall_err=0.
  - step_req edge register=0.
- Edge detection:
  - d_q <= clk_div every clk.
  - tick = (clk_div != d_q), combinational.
  - rise_pulse <= clk_div & ~d_q; fall_pulse <= ~clk_div & d_q. Both registered, so each pulse appears one clk after the edge is first sampled.
  - rise_pulse and fall_pulse toggle in every state, including IDLE.
- FSM states: IDLE, RUN, STEP, DRAIN.
- IDLE:
  - phase held at 0; no phase_en.
  - If run=1, go to RUN.
  - Else, on a step_req rising edge (step_req=1 and previous sample 0), go to STEP.
  - run and a step_req edge in the same cycle: run wins and the step is discarded.
- Phase issue (RUN, STEP, DRAIN) on each clk with tick=1:
  - phase_en <= onehot(phase).
  - phase <= (phase==NUM_PHASES-1) ? 0 : phase+1.
  - Both rising and falling clk_div edges are ticks.
  - With the divider toggling every 2 clk, phase strobes are 2 clk apart and one instruction cycle is 2*NUM_PHASES clk.
- Wrap: the tick that issues phase NUM_PHASES-1 ends the instruction cycle.
  - cycle_cnt increments on that same clk edge; it is 32-bit and wraps 0xFFFFFFFF -> 0.
  - RUN: stay in RUN if run=1; otherwise go to IDLE.
  - STEP: step_ack <= 1 for that one cycle, then go to IDLE.
  - DRAIN: go to IDLE.
- RUN with run=0 and phase!=0: go to DRAIN. The instruction cycle always completes; it is never truncated.
- RUN with run=0 and phase==0: go to IDLE directly.
- STEP ignores run until the step completes.
- step_req edges outside IDLE are ignored, not queued.
- busy = (state!=IDLE), registered with the state.

Optional Feature:
- Macro name: CLOCK_PHASE_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A gap counter resets on every tick and on IDLE, and increments each clk while busy.
  - When the counter reaches MAX_GAP, stall_err <= 1 (sticky until reset) and state is forced to IDLE.
  - On that forced exit: phase=0, and no step_ack is issued.
  - While stall_err=1, run and step_req are ignored.
- Without the macro: no gap counter exists, stall_err is tied to 0, and the FSM never aborts.

Test Plan:
All scenarios use NUM_PHASES=4, and the bench drives clk_div toggling every 2 clk unless stated.
1. Release reset, run=1 -> phase_en = 0001, 0010, 0100, 1000 on consecutive ticks 2 clk apart; cycle_cnt=1 on the 1000 strobe; pattern repeats; busy=1.
2. Drop run right after the 0010 strobe -> 0100 and 1000 still issued, then IDLE; busy=0, phase=0, cycle_cnt incremented by 1, no further strobes.
3. IDLE, run=0, step_req pulses 0->1 -> exactly four strobes; step_ack=1 only in the cycle of the 1000 strobe; second step_req edge while in STEP has no effect.
4. IDLE, run and step_req rise in the same cycle -> RUN entered; step_ack never asserts; deasserting run later yields a normal drain.
5. Assert reset asynchronously mid-RUN at phase=2 -> all outputs 0 and cycle_cnt=0 before the next clk edge; after release, IDLE with phase=0.
6. (CLOCK_PHASE_SEQ_WATCHDOG_EN) in RUN, hold clk_div constant -> stall_err=1 after 8 clk; state IDLE, busy=0; run=1 then ignored until reset.

Source files
------------

// File: rtl/clock_phase_seq.sv
// clock_phase_seq
//
// Purpose:
//   Turns the divided-clock level from the clock divider into single-cycle,
//   one-hot phase-enable strobes on the fast clock. Each clk_div edge (rising
//   or falling) issues one phase, and NUM_PHASES phases make up one
//   instruction cycle. Run/halt control, a single-step handshake and a
//   completed-instruction-cycle counter let all processor stages run on clk
//   with enables instead of on a derived clock.
//
// Ports:
//   clk        in   fast system clock (single clock domain)
//   reset      in   asynchronous, active-high reset
//   clk_div    in   divided-clock level, synchronous to clk
//   run        in   level, 1 = free-running instruction cycles
//   step_req   in   single-step request, acted on at its rising edge
//   step_ack   out  one-cycle pulse when a stepped instruction cycle completes
//   rise_pulse out  one-cycle pulse per clk_div rising edge
//   fall_pulse out  one-cycle pulse per clk_div falling edge
//   phase      out  index of the next phase to issue
//   phase_en   out  one-hot, one-cycle phase strobe
//   cycle_cnt  out  completed instruction cycles (wraps at 2^32)
//   busy       out  1 while RUN, STEP or DRAIN
//   stall_err  out  sticky watchdog flag
//
// Optional feature (macro CLOCK_PHASE_SEQ_WATCHDOG_EN):
//   Defined: a gap counter aborts to IDLE and sets stall_err when MAX_GAP clk
//   cycles pass while busy without a clk_div edge. Undefined: no gap counter,
//   stall_err is tied to 0.

module clock_phase_seq #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = 3,
  parameter int MAX_GAP    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_div,
  input  logic                  run,
  input  logic                  step_req,
  output logic                  step_ack,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [31:0]           cycle_cnt,
  output logic                  busy,
  output logic                  stall_err
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, DRAIN} state_t;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  if (NUM_PHASES < 2 || NUM_PHASES > 8 || (2 ** PHASE_W) < NUM_PHASES || MAX_GAP < 1) begin : g_param_check
    $error("clock_phase_seq: illegal NUM_PHASES/PHASE_W/MAX_GAP combination");
  end

  state_t                state_q, state_d;
  logic                  d_q;
  logic                  step_prev_q;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  rise_q, fall_q;
  logic                  step_ack_q, step_ack_d;
  logic [31:0]           cycle_cnt_q, cycle_cnt_d;
  logic                  busy_q;
  logic                  stall_q;
  logic                  abort;
  logic                  tick, step_edge, wrap, issue;

  // Any change of the sampled divider level is a phase tick; the tick that
  // issues the last phase closes the instruction cycle.
  assign tick      = clk_div ^ d_q;
  assign step_edge = step_req & ~step_prev_q;
  assign wrap      = tick && (phase_q == LAST_PHASE);

`ifdef CLOCK_PHASE_SEQ_WATCHDOG_EN
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Gap counter restarts on every tick and whenever idle. The abort fires on
  // the clk where the count would reach MAX_GAP.
  assign gap_d = (state_q == IDLE || tick) ? '0 : gap_q + GAP_W'(1);
  assign abort = (state_q != IDLE) && !tick && (gap_q == GAP_W'(MAX_GAP - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      if (abort) begin
        stall_q <= 1'b1;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign stall_q = 1'b0;
`endif

  // Next-state and phase issue. A free run dropped mid-cycle goes through
  // DRAIN so the instruction cycle is always completed. A watchdog abort
  // overrides everything and returns to IDLE at phase 0 without step_ack.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    phase_en_d  = '0;
    step_ack_d  = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (!stall_q) begin
          if (run) begin
            state_d = RUN;
          end else if (step_edge) begin
            state_d = STEP;
          end
        end
      end
      RUN: begin
        if (!run && phase_q == '0) begin
          state_d = IDLE;
        end else begin
          issue = tick;
          if (wrap) begin
            state_d = run ? RUN : IDLE;
          end else if (!run) begin
            state_d = DRAIN;
          end
        end
      end
      STEP: begin
        issue = tick;
        if (wrap) begin
          step_ack_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        issue = tick;
        if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      phase_en_d = NUM_PHASES'(1) << phase_q;
      phase_d    = wrap ? '0 : phase_q + PHASE_W'(1);
      if (wrap) begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
    end

    if (abort) begin
      state_d    = IDLE;
      phase_d    = '0;
      step_ack_d = 1'b0;
    end
  end

  // State and output registers; edge pulses are produced in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      d_q         <= 1'b0;
      step_prev_q <= 1'b0;
      phase_q     <= '0;
      phase_en_q  <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      step_ack_q  <= 1'b0;
      cycle_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= clk_div;
      step_prev_q <= step_req;
      phase_q     <= phase_d;
      phase_en_q  <= phase_en_d;
      rise_q      <= clk_div & ~d_q;
      fall_q      <= ~clk_div & d_q;
      step_ack_q  <= step_ack_d;
      cycle_cnt_q <= cycle_cnt_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign step_ack   = step_ack_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign phase      = phase_q;
  assign phase_en   = phase_en_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign busy       = busy_q;
  assign stall_err  = stall_q;

endmodule

// File: tb/tb_clock_phase_seq.sv
// tb_clock_phase_seq
//
// Self-checking bench for clock_phase_seq with NUM_PHASES=4. A directed
// vector table covers free run and drain, hand-written sequences cover
// single step, run/step collision and asynchronous reset, and a randomized
// run is compared against a behavioural model of the sequencer. The stall
// test is included when CLOCK_PHASE_SEQ_WATCHDOG_EN is defined.

module tb_clock_phase_seq;

  localparam int NP = 4;
  localparam int PW = 3;
  localparam int MAX_GAP = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_div = 1'b0;
  logic          run = 1'b0;
  logic          step_req = 1'b0;
  logic          step_ack;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [PW-1:0] phase;
  logic [NP-1:0] phase_en;
  logic [31:0]   cycle_cnt;
  logic          busy;
  logic          stall_err;

  int compared = 0;
  int mismatched = 0;
  logic cdLevel = 1'b0;

  clock_phase_seq #(
    .NUM_PHASES(NP),
    .PHASE_W(PW),
    .MAX_GAP(MAX_GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_div(clk_div),
    .run(run),
    .step_req(step_req),
    .step_ack(step_ack),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .phase(phase),
    .phase_en(phase_en),
    .cycle_cnt(cycle_cnt),
    .busy(busy),
    .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: "active" means an instruction cycle sequence is in
  // progress; "stepping" marks a single step; "stopping" marks a free run
  // that must finish its current instruction cycle and then halt.
  logic          mDprev, mStepPrev, mActive, mStepping, mStopping, mStall;
  int            mPhase, mGap;
  logic [NP-1:0] mPhaseEn;
  logic          mRise, mFall, mAck, mBusy;
  logic [31:0]   mCnt;

  task automatic modelReset();
    mDprev = 0; mStepPrev = 0; mActive = 0; mStepping = 0; mStopping = 0;
    mStall = 0; mPhase = 0; mGap = 0; mPhaseEn = '0; mRise = 0; mFall = 0;
    mAck = 0; mBusy = 0; mCnt = '0;
  endtask

  task automatic modelStep(input logic cd, input logic r, input logic s);
    logic tick, stepEdge, wasActive;
    tick      = (cd != mDprev);
    stepEdge  = s && !mStepPrev;
    wasActive = mActive;
    mRise     = cd && !mDprev;
    mFall     = !cd && mDprev;
    mPhaseEn  = '0;
    mAck      = 0;
    if (!wasActive) begin
      mPhase = 0;
      if (!mStall && (r || stepEdge)) begin
        mActive = 1; mStepping = !r; mStopping = 0;
      end
    end else if (!mStepping && !mStopping && !r && mPhase == 0) begin
      mActive = 0;
    end else begin
      if (!mStepping && !r) mStopping = 1;
      if (tick) begin
        mPhaseEn = NP'(1) << mPhase;
        if (mPhase == NP - 1) begin
          mPhase = 0;
          mCnt   = mCnt + 1;
          mAck   = mStepping;
          if (mStepping || mStopping) mActive = 0;
        end else begin
          mPhase = mPhase + 1;
        end
      end
    end
`ifdef CLOCK_PHASE_SEQ_WATCHDOG_EN
    if (!wasActive || tick) mGap = 0;
    else mGap = mGap + 1;
    if (mGap >= MAX_GAP) begin
      mStall = 1; mActive = 0; mPhase = 0; mAck = 0;
    end
`endif
    mBusy     = mActive;
    mDprev    = cd;
    mStepPrev = s;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".phase_en"},   32'(phase_en),   32'(mPhaseEn));
    check({tag, ".phase"},      32'(phase),      32'(mPhase));
    check({tag, ".cycle_cnt"},  cycle_cnt,       mCnt);
    check({tag, ".busy"},       32'(busy),       32'(mBusy));
    check({tag, ".step_ack"},   32'(step_ack),   32'(mAck));
    check({tag, ".rise_pulse"}, 32'(rise_pulse), 32'(mRise));
    check({tag, ".fall_pulse"}, 32'(fall_pulse), 32'(mFall));
    check({tag, ".stall_err"},  32'(stall_err),  32'(mStall));
  endtask

  task automatic applyStimulus(input logic cd, input logic r, input logic s);
    clk_div  = cd;
    run      = r;
    step_req = s;
    modelStep(cd, r, s);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1; clk_div = 0; run = 0; step_req = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    modelReset();
    cdLevel = 0;
  endtask

  typedef struct packed {
    logic        cd;
    logic        run;
    logic        step;
    logic [3:0]  en;
    logic [2:0]  ph;
    logic [31:0] cnt;
    logic        busy;
    logic        ack;
    logic        rise;
    logic        fall;
  } VectorRec;

  function automatic VectorRec mk(input logic cd, input logic r, input logic s, input int en,
                                  input int ph, input int cnt, input logic b, input logic a,
                                  input logic ri, input logic fa);
    VectorRec v;
    v.cd = cd; v.run = r; v.step = s; v.en = 4'(en); v.ph = 3'(ph); v.cnt = 32'(cnt);
    v.busy = b; v.ack = a; v.rise = ri; v.fall = fa;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL time_limit: got no finish, expected finish before limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    VectorRec vecs[20];
    logic [NP-1:0] seen[$];
    int acks, ackOnLast, stallAt, busyHigh, strobes, holdLeft;
    logic runLvl, stepLvl;

    // Free run for one full instruction cycle, then run drops right after
    // the 0010 strobe of the second cycle; run=1 at row 14 lands in DRAIN.
    vecs[0]  = mk(0,1,0, 0,0,0, 1,0,0,0);
    vecs[1]  = mk(1,1,0, 1,1,0, 1,0,1,0);
    vecs[2]  = mk(1,1,0, 0,1,0, 1,0,0,0);
    vecs[3]  = mk(0,1,0, 2,2,0, 1,0,0,1);
    vecs[4]  = mk(0,1,0, 0,2,0, 1,0,0,0);
    vecs[5]  = mk(1,1,0, 4,3,0, 1,0,1,0);
    vecs[6]  = mk(1,1,0, 0,3,0, 1,0,0,0);
    vecs[7]  = mk(0,1,0, 8,0,1, 1,0,0,1);
    vecs[8]  = mk(0,1,0, 0,0,1, 1,0,0,0);
    vecs[9]  = mk(1,1,0, 1,1,1, 1,0,1,0);
    vecs[10] = mk(1,1,0, 0,1,1, 1,0,0,0);
    vecs[11] = mk(0,1,0, 2,2,1, 1,0,0,1);
    vecs[12] = mk(0,0,0, 0,2,1, 1,0,0,0);
    vecs[13] = mk(1,0,0, 4,3,1, 1,0,1,0);
    vecs[14] = mk(1,1,0, 0,3,1, 1,0,0,0);
    vecs[15] = mk(0,0,0, 8,0,2, 0,0,0,1);
    vecs[16] = mk(0,0,0, 0,0,2, 0,0,0,0);
    vecs[17] = mk(1,0,0, 0,0,2, 0,0,1,0);
    vecs[18] = mk(1,0,0, 0,0,2, 0,0,0,0);
    vecs[19] = mk(0,0,0, 0,0,2, 0,0,0,1);

    doReset();
    check("reset.phase_en", 32'(phase_en), 32'd0);
    check("reset.cycle_cnt", cycle_cnt, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.phase", 32'(phase), 32'd0);

    // Directed table: free run and drain.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].cd, vecs[i].run, vecs[i].step);
      check($sformatf("tbl%0d.phase_en", i), 32'(phase_en), 32'(vecs[i].en));
      check($sformatf("tbl%0d.phase", i), 32'(phase), 32'(vecs[i].ph));
      check($sformatf("tbl%0d.cycle_cnt", i), cycle_cnt, vecs[i].cnt);
      check($sformatf("tbl%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("tbl%0d.step_ack", i), 32'(step_ack), 32'(vecs[i].ack));
      check($sformatf("tbl%0d.rise", i), 32'(rise_pulse), 32'(vecs[i].rise));
      check($sformatf("tbl%0d.fall", i), 32'(fall_pulse), 32'(vecs[i].fall));
      check($sformatf("tbl%0d.stall_err", i), 32'(stall_err), 32'd0);
    end

    // Single step with a second step_req edge while stepping.
    seen.delete(); acks = 0; ackOnLast = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) cdLevel = !cdLevel;
      applyStimulus(cdLevel, 1'b0, (i == 0 || i == 2));
      if (phase_en != '0) seen.push_back(phase_en);
      if (step_ack) begin
        acks++;
        if (phase_en == 4'b1000) ackOnLast++;
      end
    end
    check("step.strobes", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      check("step.strobe0", 32'(seen[0]), 32'h1);
      check("step.strobe1", 32'(seen[1]), 32'h2);
      check("step.strobe2", 32'(seen[2]), 32'h4);
      check("step.strobe3", 32'(seen[3]), 32'h8);
    end
    check("step.acks", 32'(acks), 32'd1);
    check("step.ack_on_last", 32'(ackOnLast), 32'd1);
    check("step.busy", 32'(busy), 32'd0);
    check("step.cycle_cnt", cycle_cnt, 32'd3);

    // run and step_req rise together: run wins, then a normal drain.
    seen.delete(); acks = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 1) cdLevel = !cdLevel;
      applyStimulus(cdLevel, (i < 12), (i == 0));
      if (phase_en != '0) seen.push_back(phase_en);
      if (step_ack) acks++;
    end
    check("collide.acks", 32'(acks), 32'd0);
    check("collide.strobes", 32'(seen.size()), 32'd8);
    if (seen.size() > 0) check("collide.last_strobe", 32'(seen[seen.size()-1]), 32'h8);
    check("collide.busy", 32'(busy), 32'd0);
    check("collide.phase", 32'(phase), 32'd0);
    check("collide.cycle_cnt", cycle_cnt, 32'd5);

    // Asynchronous reset in the middle of RUN at phase 2.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    check("areset.pre_phase", 32'(phase), 32'd2);
    #2;
    reset = 1;
    #1;
    check("areset.phase_en", 32'(phase_en), 32'd0);
    check("areset.phase", 32'(phase), 32'd0);
    check("areset.cycle_cnt", cycle_cnt, 32'd0);
    check("areset.busy", 32'(busy), 32'd0);
    check("areset.step_ack", 32'(step_ack), 32'd0);
    check("areset.rise", 32'(rise_pulse), 32'd0);
    check("areset.fall", 32'(fall_pulse), 32'd0);
    check("areset.stall_err", 32'(stall_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    modelReset();
    cdLevel = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    check("areset.post_busy", 32'(busy), 32'd0);
    check("areset.post_phase", 32'(phase), 32'd0);
    checkOutput("areset.post");

    // Randomized traffic against the model.
    holdLeft = $urandom_range(1, 3);
    runLvl = 0;
    for (int i = 0; i < 2000; i++) begin
      if (holdLeft == 0) begin
        cdLevel = !cdLevel;
        holdLeft = $urandom_range(1, 3);
      end
      holdLeft--;
      if ($urandom_range(0, 15) == 0) runLvl = !runLvl;
      stepLvl = ($urandom_range(0, 3) == 0);
      applyStimulus(cdLevel, runLvl, stepLvl);
      checkOutput("rand");
    end

`ifdef CLOCK_PHASE_SEQ_WATCHDOG_EN
    // Divider stops while running: abort after MAX_GAP clk, then locked out.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    stallAt = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("wd");
      if (stall_err === 1'b1 && stallAt < 0) stallAt = i + 1;
    end
    check("wd.stall_cycle", 32'(stallAt), 32'd8);
    check("wd.busy", 32'(busy), 32'd0);
    check("wd.phase", 32'(phase), 32'd0);
    busyHigh = 0; strobes = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 1) cdLevel = !cdLevel;
      applyStimulus(cdLevel, 1'b1, (i % 4 == 0));
      if (busy) busyHigh++;
      if (phase_en != '0) strobes++;
    end
    check("wd.locked_busy", 32'(busyHigh), 32'd0);
    check("wd.locked_strobes", 32'(strobes), 32'd0);
    check("wd.sticky", 32'(stall_err), 32'd1);
    doReset();
    check("wd.cleared", 32'(stall_err), 32'd0);
`else
    stallAt = 0; busyHigh = 0; strobes = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
